// File: rtl/mpu_data_types.sv
// Shared types and sizing for the matrix processing unit: instruction encoding,
// controller states, per-register matrix shapes and scoreboard unit indices.
package mpu_data_types;

    localparam int MATRIX_REGISTERS = 8;
    localparam int M                = 3;
    localparam int N                = 3;
    localparam int MBITS            = $clog2(M);
    localparam int NBITS            = $clog2(N);
    localparam int MATRIX_REG_BITS  = $clog2(MATRIX_REGISTERS) - 1;

    localparam logic [MBITS:0] M_MAX = M[MBITS:0];
    localparam logic [NBITS:0] N_MAX = N[NBITS:0];

    // Execution units tracked by the scoreboard, used as bit indices.
    localparam int NUM_UNITS  = 3;
    localparam int UNIT_LOAD  = 0;
    localparam int UNIT_STORE = 1;
    localparam int UNIT_MULT  = 2;

    typedef enum logic [1:0] {
        MPU_NOP   = 2'd0,
        MPU_LOAD  = 2'd1,
        MPU_STORE = 2'd2,
        MPU_MULT  = 2'd3
    } mpu_instruction_e;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_HOLD = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [MBITS:0] m;
        logic [NBITS:0] n;
    } matrix_dim_t;

    typedef logic [MATRIX_REG_BITS:0]  reg_addr_t;
    typedef logic [MATRIX_REGISTERS-1:0] reg_mask_t;

    function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
        reg_mask_t mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/mpu_scoreboard.sv
// Register scoreboard: tracks which matrix registers are owned by an in-flight
// unit operation, and which of the load/store/multiply units are busy.
module mpu_scoreboard
    import mpu_data_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] issue,
    input  reg_mask_t            issue_mask,
    input  logic [NUM_UNITS-1:0] done,
    input  reg_mask_t            query_mask,
    output reg_mask_t            reg_busy,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic                 query_conflict
);

    reg_mask_t            unit_mask [NUM_UNITS];
    logic [NUM_UNITS-1:0] retire;
    reg_mask_t            retire_mask;
    reg_mask_t            set_mask;

    // A done pulse only counts for a unit that actually has work outstanding.
    assign retire         = done & unit_busy;
    assign set_mask       = (|issue) ? issue_mask : '0;
    assign query_conflict = |(reg_busy & query_mask);

    always_comb begin
        retire_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (retire[u]) begin
                retire_mask = retire_mask | unit_mask[u];
            end
        end
    end

    // Issue and retire masks never overlap, so clear-then-set is order independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_busy  <= '0;
            unit_busy <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_mask[u] <= '0;
            end
        end else begin
            reg_busy <= (reg_busy & ~retire_mask) | set_mask;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (issue[u]) begin
                    unit_busy[u] <= 1'b1;
                    unit_mask[u] <= issue_mask;
                end else if (retire[u]) begin
                    unit_busy[u] <= 1'b0;
                    unit_mask[u] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mpu_controller.sv
// In-order issue controller for the MPU: accepts one instruction at a time,
// validates operand shapes, waits out register/unit hazards, then starts a unit.
module mpu_controller
    import mpu_data_types::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    output logic                   ready_o,
    input  mpu_instruction_e       op_i,
    input  logic [MBITS:0]         m_in_i,
    input  logic [NBITS:0]         n_in_i,
    input  logic [MATRIX_REG_BITS:0] src_addr_0_i,
    input  logic [MATRIX_REG_BITS:0] src_addr_1_i,
    input  logic [MATRIX_REG_BITS:0] dest_addr_i,
    output logic                   load_start_o,
    output logic [MATRIX_REG_BITS:0] load_dest_o,
    input  logic                   load_done_i,
    output logic                   store_start_o,
    output logic [MATRIX_REG_BITS:0] store_src_o,
    input  logic                   store_done_i,
    output logic                   mult_start_o,
    output logic [MATRIX_REG_BITS:0] mult_src0_o,
    output logic [MATRIX_REG_BITS:0] mult_src1_o,
    output logic [MATRIX_REG_BITS:0] mult_dest_o,
    output logic [MBITS:0]         mult_m_o,
    output logic [NBITS:0]         mult_k_o,
    output logic [NBITS:0]         mult_n_o,
    input  logic                   mult_done_i,
    output logic                   dim_err_o,
    output logic [MATRIX_REGISTERS-1:0] reg_busy_o,
    output logic                   idle_o
);

    ctrl_state_e      state_q, state_d;
    mpu_instruction_e op_q;
    logic [MBITS:0]   m_q;
    logic [NBITS:0]   n_q;
    reg_addr_t        src0_q, src1_q, dest_q;
    matrix_dim_t      dims_q [MATRIX_REGISTERS];

    matrix_dim_t          dim_src0, dim_src1;
    logic                 accept;
    logic                 reject;
    logic                 dim_err;
    reg_mask_t            touch_mask;
    logic [NUM_UNITS-1:0] unit_req;
    logic [NUM_UNITS-1:0] issue;
    logic [NUM_UNITS-1:0] done_vec;
    logic [NUM_UNITS-1:0] unit_busy;
    logic                 query_conflict;

    assign accept   = req_i && (state_q == CTRL_IDLE);
    assign dim_src0 = dims_q[src0_q];
    assign dim_src1 = dims_q[src1_q];
    assign ready_o  = (state_q == CTRL_IDLE);
    assign idle_o   = (state_q == CTRL_IDLE) && !(|unit_busy);

    always_comb begin
        done_vec             = '0;
        done_vec[UNIT_LOAD]  = load_done_i;
        done_vec[UNIT_STORE] = store_done_i;
        done_vec[UNIT_MULT]  = mult_done_i;
    end

    mpu_scoreboard u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .issue          (issue),
        .issue_mask     (touch_mask),
        .done           (done_vec),
        .query_mask     (touch_mask),
        .reg_busy       (reg_busy_o),
        .unit_busy      (unit_busy),
        .query_conflict (query_conflict)
    );

    // Decode the held instruction into its validity, touched registers and target unit.
    always_comb begin
        reject     = 1'b0;
        touch_mask = '0;
        unit_req   = '0;
        case (op_q)
            MPU_LOAD: begin
                reject = (m_q == '0) || (m_q > M_MAX) || (n_q == '0) || (n_q > N_MAX);
                touch_mask          = reg_onehot(dest_q);
                unit_req[UNIT_LOAD] = 1'b1;
            end
            MPU_STORE: begin
                reject               = (dim_src0.m == '0);
                touch_mask           = reg_onehot(src0_q);
                unit_req[UNIT_STORE] = 1'b1;
            end
            MPU_MULT: begin
                reject = (dim_src0.m == '0) || (dim_src1.m == '0) || (dim_src0.n != dim_src1.m);
                touch_mask          = reg_onehot(src0_q) | reg_onehot(src1_q) | reg_onehot(dest_q);
                unit_req[UNIT_MULT] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Shape errors are dropped at once; hazards keep the instruction parked in HOLD.
    always_comb begin
        state_d = state_q;
        issue   = '0;
        dim_err = 1'b0;
        case (state_q)
            CTRL_IDLE: begin
                if (req_i) begin
                    state_d = CTRL_HOLD;
                end
            end
            CTRL_HOLD: begin
                if (op_q == MPU_NOP) begin
                    state_d = CTRL_IDLE;
                end else if (reject) begin
                    dim_err = 1'b1;
                    state_d = CTRL_IDLE;
                end else if (!query_conflict && !(|(unit_req & unit_busy))) begin
                    issue   = unit_req;
                    state_d = CTRL_IDLE;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CTRL_IDLE;
            op_q    <= MPU_NOP;
            m_q     <= '0;
            n_q     <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_i;
                m_q    <= m_in_i;
                n_q    <= n_in_i;
                src0_q <= src_addr_0_i;
                src1_q <= src_addr_1_i;
                dest_q <= dest_addr_i;
            end
        end
    end

    // Shapes are recorded at issue so a following instruction validates against them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < MATRIX_REGISTERS; r++) begin
                dims_q[r] <= '0;
            end
        end else if (issue[UNIT_LOAD]) begin
            dims_q[dest_q] <= '{m: m_q, n: n_q};
        end else if (issue[UNIT_MULT]) begin
            dims_q[dest_q] <= '{m: dim_src0.m, n: dim_src1.n};
        end
    end

    // Start pulses last one cycle; operand outputs hold until the next issue to that unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_start_o  <= 1'b0;
            store_start_o <= 1'b0;
            mult_start_o  <= 1'b0;
            dim_err_o     <= 1'b0;
            load_dest_o   <= '0;
            store_src_o   <= '0;
            mult_src0_o   <= '0;
            mult_src1_o   <= '0;
            mult_dest_o   <= '0;
            mult_m_o      <= '0;
            mult_k_o      <= '0;
            mult_n_o      <= '0;
        end else begin
            load_start_o  <= issue[UNIT_LOAD];
            store_start_o <= issue[UNIT_STORE];
            mult_start_o  <= issue[UNIT_MULT];
            dim_err_o     <= dim_err;
            if (issue[UNIT_LOAD]) begin
                load_dest_o <= dest_q;
            end
            if (issue[UNIT_STORE]) begin
                store_src_o <= src0_q;
            end
            if (issue[UNIT_MULT]) begin
                mult_src0_o <= src0_q;
                mult_src1_o <= src1_q;
                mult_dest_o <= dest_q;
                mult_m_o    <= dim_src0.m;
                mult_k_o    <= dim_src0.n;
                mult_n_o    <= dim_src1.n;
            end
        end
    end

endmodule

// File: doc/mpu_controller.md
Name: mpu_controller

Overview:
In-order issue controller for the matrix processing unit. It accepts one MPU instruction at a time (NOP/LOAD/STORE/MULT) and sequences the load unit, store unit and multiply dispatcher. A register scoreboard blocks hazards between instructions. A per-register dimension table rejects multiplies whose operand shapes do not match.

Parameters:
MATRIX_REGISTERS, 8 (global_defs), number of matrix registers tracked
M, 3 (global_defs), maximum rows
N, 3 (global_defs), maximum columns

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_i  in  1  instruction valid
ready_o  out  1  controller can accept an instruction this cycle
op_i  in  mpu_instruction_e  instruction
m_in_i  in  MBITS+1  rows (LOAD only)
n_in_i  in  NBITS+1  columns (LOAD only)
src_addr_0_i, src_addr_1_i, dest_addr_i  in  MATRIX_REG_BITS+1 each  register addresses
load_start_o  out  1  one-cycle start pulse to load unit
load_dest_o  out  MATRIX_REG_BITS+1  load target register
load_done_i  in  1  load unit completion pulse
store_start_o  out  1  one-cycle start pulse to store unit
store_src_o  out  MATRIX_REG_BITS+1  store source register
store_done_i  in  1  store completion pulse
mult_start_o  out  1  one-cycle start pulse to dispatcher
mult_src0_o, mult_src1_o, mult_dest_o  out  MATRIX_REG_BITS+1 each  multiply operands and destination
mult_m_o, mult_k_o, mult_n_o  out  MBITS+1/NBITS+1  shape of the multiply: (m×k)·(k×n)
mult_done_i  in  1  collector write-back completion pulse
dim_err_o  out  1  one-cycle pulse: instruction rejected
reg_busy_o  out  MATRIX_REGISTERS  scoreboard vector
idle_o  out  1  in CTRL_IDLE and no unit busy

Behaviour:
- Reset (asynchronous):
  - State goes to CTRL_IDLE.
  - All start outputs, dim_err_o, reg_busy_o, unit-busy flags and the dimension table are cleared to 0.
  - ready_o=1 and idle_o=1.
  - Address outputs and shape outputs are 0.
  - Reset mid-operation abandons all in-flight tracking. Done pulses arriving after reset are ignored.
- FSM ctrl_state_e {CTRL_IDLE, CTRL_HOLD}:
  - ready_o = (state==CTRL_IDLE).
  - When req_i&&ready_o at an edge, the controller latches the instruction and moves to CTRL_HOLD.
- CTRL_HOLD evaluates the latched instruction every cycle, using registered scoreboard and dimension state only. There is no same-cycle bypass of a done pulse.
  - NOP: move to CTRL_IDLE; no side effects.
  - Validation (checked first). On failure: dim_err_o pulses the next cycle, the instruction is dropped, state returns to CTRL_IDLE, and no scoreboard change occurs.
    - LOAD fails if m_in==0, m_in>M, n_in==0 or n_in>N.
    - STORE fails if dims[src0].m==0 (register never written).
    - MULT fails if either source has m==0, or dims[src0].n != dims[src1].m.
  - Hazard check: every register touched must be non-busy, and the target unit must be idle.
    - LOAD touches dest.
    - STORE touches src0.
    - MULT touches src0, src1 and dest (a duplicated address counts once).
    - If the check fails, the controller stays in CTRL_HOLD.
  - Issue: at the edge, the controller:
    - asserts the unit's start_o for exactly one cycle, with addresses and shape held stable until the next issue to that unit;
    - sets the busy bits for the touched registers and records them as that unit's mask;
    - sets the unit-busy flag;
    - returns to CTRL_IDLE.
  - Dimension table updates at issue:
    - LOAD writes dims[dest]={m_in,n_in}.
    - MULT writes dims[dest]={dims[src0].m, dims[src1].n}.
    - Outputs: mult_m = dims[src0].m, mult_k = dims[src0].n, mult_n = dims[src1].n.
- Timing and latency:
  - Minimum latency from accept edge to start_o high is 2 cycles.
  - A new instruction can be accepted in the cycle start_o is high, giving 1 instruction per 2 cycles best case.
- Completion:
  - unit done_i clears that unit's busy flag and the registers in its mask at the edge.
  - done_i for a unit that is not busy is ignored.
  - Done for unit X and issue to unit Y at the same edge both apply; their masks are disjoint by construction.
  - Simultaneous done pulses from all three units are all honoured.
- Units run concurrently; only the issue order is serialised.

Decomposition:
- Add to mpu_data_types:
  - ctrl_state_e {CTRL_IDLE, CTRL_HOLD};
  - struct matrix_dim_t {m [MBITS:0], n [NBITS:0]}.
- Sub-module mpu_scoreboard holds:
  - the busy vector;
  - the three per-unit masks and busy flags;
  - set/clear ports and hazard query outputs.

Test Plan:
- LOAD m=3,n=3 dest=2 → load_start_o high 2 cycles after accept, load_dest_o=2, reg_busy_o=8'h04; load_done_i → reg_busy_o=0, idle_o=1.
- LOAD r0 (2×3), LOAD r1 (3×2), MULT src0=0 src1=1 dest=4 → mult_start_o only after both load_done_i; mult_m/k/n=2/3/2; MULT dest=4 → STORE src0=4 is accepted, stalls until mult_done_i, and store_start_o is next cycle+1.
- LOAD r0 (2×3), LOAD r1 (2×3), MULT 0·1→2 → dim_err_o one pulse, no mult_start_o, reg_busy_o unchanged; LOAD with m_in=0 → dim_err_o.
- Busy mult on r0/r1/r2, then LOAD dest=5 → load_start_o issued while mult is still busy; LOAD dest=1 → held in CTRL_HOLD with ready_o=0 until mult_done_i.
- rst asserted while load and mult are in flight → all outputs 0, ready_o=1 in the same cycle (async); a late load_done_i is ignored; STORE src0=0 → dim_err_o.
- Spurious store_done_i with store idle, plus NOP → no state change, no pulses, ready_o returns 1 after one hold cycle.
